core_scheduler: RTL

- Per-core control FSM that sequences the instruction pipeline through IDLE/FETCH/DECODE/REQUEST/WAIT/EXECUTE/UPDATE/DONE.
- Broadcasts `core_state` to the fetcher, decoder, per-thread ALUs, LSUs and PC units.
- Reconciles the per-thread `next_pc` values into the single core `current_pc`.
- Flags branch divergence and counts retired instructions.

---
 rtl/gpu_pkg.sv | 39 +++
 rtl/core_scheduler_lane_reduce.sv | 30 +++
 rtl/core_scheduler.sv | 126 ++++++++++++
 3 files changed

// File: rtl/gpu_pkg.sv
// Shared GPU core definitions: state encodings used by the scheduler, fetcher,
// LSUs and PC units, plus default width parameters.
package gpu_pkg;

  localparam int THREADS_PER_BLOCK_DEF     = 4;
  localparam int PROGRAM_MEM_ADDR_BITS_DEF = 8;
  localparam int RETIRE_CNT_BITS_DEF       = 16;

  // The PC and ALU units decode these codes directly, so the values are fixed.
  typedef enum logic [2:0] {
    CORE_IDLE    = 3'd0,
    CORE_FETCH   = 3'd1,
    CORE_DECODE  = 3'd2,
    CORE_REQUEST = 3'd3,
    CORE_WAIT    = 3'd4,
    CORE_EXECUTE = 3'd5,
    CORE_UPDATE  = 3'd6,
    CORE_DONE    = 3'd7
  } core_state_e;

  typedef enum logic [2:0] {
    FETCHER_IDLE     = 3'd0,
    FETCHER_FETCHING = 3'd1,
    FETCHER_FETCHED  = 3'd2
  } fetcher_state_e;

  typedef enum logic [1:0] {
    LSU_IDLE       = 2'd0,
    LSU_REQUESTING = 2'd1,
    LSU_WAITING    = 2'd2,
    LSU_DONE       = 2'd3
  } lsu_state_e;

  // A lane holds the core in WAIT while its memory access is outstanding.
  function automatic logic lsu_busy(input logic [1:0] state);
    return (state == LSU_REQUESTING) || (state == LSU_WAITING);
  endfunction

endpackage

// File: rtl/core_scheduler_lane_reduce.sv
// Reduces per-lane LSU status and next-PC values over the enabled lanes into
// a single "any lane busy" and "any lane disagrees with lane 0" pair.
module lane_reduce
  import gpu_pkg::*;
#(
  parameter int THREADS_PER_BLOCK = THREADS_PER_BLOCK_DEF,
  parameter int ADDR_BITS         = PROGRAM_MEM_ADDR_BITS_DEF,
  parameter int TC_BITS           = $clog2(THREADS_PER_BLOCK) + 1
) (
  input  logic [TC_BITS-1:0]                     thread_count,
  input  logic [2*THREADS_PER_BLOCK-1:0]         lsu_state,
  input  logic [ADDR_BITS*THREADS_PER_BLOCK-1:0] next_pc,
  output logic                                   lsu_busy_any,
  output logic                                   pc_mismatch_any
);

  // Lane i is enabled iff i < thread_count; counts above the lane total enable all.
  always_comb begin
    lsu_busy_any    = 1'b0;
    pc_mismatch_any = 1'b0;
    for (int i = 0; i < THREADS_PER_BLOCK; i++) begin
      lsu_busy_any = lsu_busy_any
                   | ((TC_BITS'(i) < thread_count) && lsu_busy(lsu_state[2*i +: 2]));
      pc_mismatch_any = pc_mismatch_any
                      | ((i > 0) && (TC_BITS'(i) < thread_count)
                         && (next_pc[ADDR_BITS*i +: ADDR_BITS] != next_pc[ADDR_BITS-1:0]));
    end
  end

endmodule

// File: rtl/core_scheduler.sv
// Per-core control FSM: sequences fetch/decode/memory/execute/update, adopts
// lane 0's next PC, flags branch divergence and counts retired instructions.
module core_scheduler
  import gpu_pkg::*;
#(
  parameter int THREADS_PER_BLOCK     = THREADS_PER_BLOCK_DEF,
  parameter int PROGRAM_MEM_ADDR_BITS = PROGRAM_MEM_ADDR_BITS_DEF,
  parameter int RETIRE_CNT_BITS       = RETIRE_CNT_BITS_DEF
) (
  input  logic                                               clk,
  input  logic                                               reset,
  input  logic                                               start,
  input  logic [$clog2(THREADS_PER_BLOCK):0]                 thread_count,
  input  logic [2:0]                                         fetcher_state,
  input  logic [2*THREADS_PER_BLOCK-1:0]                     lsu_state,
  input  logic                                               decoded_ret,
  input  logic [PROGRAM_MEM_ADDR_BITS*THREADS_PER_BLOCK-1:0] next_pc,
  output logic [2:0]                                         core_state,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0]                   current_pc,
  output logic                                               done,
  output logic                                               divergence,
  output logic [RETIRE_CNT_BITS-1:0]                         retired
);

  localparam int TC_BITS = $clog2(THREADS_PER_BLOCK) + 1;

  core_state_e                      state_q, state_d;
  logic [PROGRAM_MEM_ADDR_BITS-1:0] pc_q, pc_d;
  logic                             done_q, done_d;
  logic                             div_q, div_d;
  logic [RETIRE_CNT_BITS-1:0]       retired_q, retired_d;
  logic                             lsu_busy_any_s;
  logic                             pc_mismatch_any_s;

  lane_reduce #(
    .THREADS_PER_BLOCK (THREADS_PER_BLOCK),
    .ADDR_BITS         (PROGRAM_MEM_ADDR_BITS),
    .TC_BITS           (TC_BITS)
  ) u_lane_reduce (
    .thread_count    (thread_count),
    .lsu_state       (lsu_state),
    .next_pc         (next_pc),
    .lsu_busy_any    (lsu_busy_any_s),
    .pc_mismatch_any (pc_mismatch_any_s)
  );

  // Next-state and next-output logic; every register holds unless updated.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    done_d    = done_q;
    div_d     = div_q;
    retired_d = retired_q;
    case (state_q)
      CORE_IDLE: begin
        if (start) begin
          state_d   = CORE_FETCH;
          pc_d      = '0;
          retired_d = '0;
          div_d     = 1'b0;
        end else begin
          state_d = CORE_IDLE;
        end
      end
      CORE_FETCH: begin
        if (fetcher_state == FETCHER_FETCHED) begin
          state_d = CORE_DECODE;
        end else begin
          state_d = CORE_FETCH;
        end
      end
      CORE_DECODE:  state_d = CORE_REQUEST;
      CORE_REQUEST: state_d = CORE_WAIT;
      CORE_WAIT: begin
        if (!lsu_busy_any_s) begin
          state_d = CORE_EXECUTE;
        end else begin
          state_d = CORE_WAIT;
        end
      end
      CORE_EXECUTE: state_d = CORE_UPDATE;
      CORE_UPDATE: begin
        // Saturate rather than wrap so a long-running block never reads as short.
        if (retired_q != {RETIRE_CNT_BITS{1'b1}}) begin
          retired_d = retired_q + RETIRE_CNT_BITS'(1);
        end else begin
          retired_d = retired_q;
        end
        div_d = div_q | pc_mismatch_any_s;
        if (decoded_ret) begin
          state_d = CORE_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = CORE_FETCH;
          pc_d    = next_pc[PROGRAM_MEM_ADDR_BITS-1:0];
        end
      end
      CORE_DONE:    state_d = CORE_DONE;
      default:      state_d = CORE_IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= CORE_IDLE;
      pc_q      <= '0;
      done_q    <= 1'b0;
      div_q     <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      done_q    <= done_d;
      div_q     <= div_d;
      retired_q <= retired_d;
    end
  end

  assign core_state = state_q;
  assign current_pc = pc_q;
  assign done       = done_q;
  assign divergence = div_q;
  assign retired    = retired_q;

endmodule
